// File: rtl/uart_tx_device.sv
// uart_tx_device: memory-mapped 8N1 UART transmitter with a small TX FIFO and completion interrupt
module uart_tx_device #(
  parameter int          FifoDepth = 4,
  parameter logic [15:0] ResetDiv  = 16'd433
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        tx_o,
  output logic        irq_o
);
  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [FifoDepth];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] level;
  logic [15:0]   div, cnt;
  logic [7:0]    sh;
  logic [2:0]    bit_cnt;
  logic          en, irq_en, ovf;

  logic [7:0]  idx;
  logic        full, empty, busy, bit_end, pop, wr, push, push_ok, mapped;
  logic [31:0] status, rd_val;
  logic        unused;

  assign idx     = addr_i[9:2];
  assign full    = level == CW'(FifoDepth);
  assign empty   = level == '0;
  assign busy    = state != IDLE;
  assign bit_end = cnt == '0;
  // a frame starts from IDLE, or straight out of a finished stop bit for gapless back-to-back frames
  assign pop     = en & ~empty & (state == IDLE | (state == STOP & bit_end));
  assign wr      = req_i & we_i;
  assign push    = wr & idx == 8'd0 & be_i[0];
  assign push_ok = push & (~full | pop);
  assign mapped  = idx < 8'd4;
  assign status  = 32'({level, ovf, busy, empty, full});
  assign rd_val  = idx == 8'd1 ? status : idx == 8'd2 ? {14'b0, irq_en, en, div} : 32'd0;
  assign unused  = ^{addr_i[31:10], addr_i[1:0], wdata_i[31:18], be_i[3]};

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= wdata_i[7:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      level    <= '0;
      ovf      <= 1'b0;
      div      <= ResetDiv;
      en       <= 1'b0;
      irq_en   <= 1'b0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      err_o    <= 1'b0;
      irq_o    <= 1'b0;
    end else begin
      rd_ptr   <= rd_ptr + AW'(pop);
      wr_ptr   <= wr_ptr + AW'(push_ok);
      level    <= level + CW'(push_ok) - CW'(pop);
      ovf      <= (push & ~push_ok) | (ovf & ~(wr & idx == 8'd3 & wdata_i[0]));
      if (wr & idx == 8'd2 & be_i[0]) div[7:0] <= wdata_i[7:0];
      if (wr & idx == 8'd2 & be_i[1]) div[15:8] <= wdata_i[15:8];
      if (wr & idx == 8'd2 & be_i[2]) {irq_en, en} <= wdata_i[17:16];
      rvalid_o <= req_i;
      rdata_o  <= (req_i & ~we_i & mapped) ? rd_val : 32'd0;
      err_o    <= req_i & ~mapped;
      irq_o    <= irq_en & empty & ~busy;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      tx_o    <= 1'b1;
      cnt     <= '0;
      sh      <= '0;
      bit_cnt <= '0;
    end else if (pop) begin
      state <= START;
      sh    <= mem[rd_ptr];
      tx_o  <= 1'b0;
      cnt   <= div;
    end else if (state != IDLE) begin
      if (!bit_end) cnt <= cnt - 16'd1;
      else begin
        cnt <= div;
        case (state)
          START: begin
            state   <= DATA;
            tx_o    <= sh[0];
            bit_cnt <= '0;
          end
          DATA: begin
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx_o  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              sh      <= sh >> 1;
              tx_o    <= sh[1];
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_device.sv
// tb_uart_tx_device: randomized self-checking bench for uart_tx_device against a queue-based model
module tb_uart_tx_device;
  localparam int DEPTH = 4;

  logic        clk = 0, rst = 0, req = 0, we = 0;
  logic [3:0]  be = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic        rvalid, err, tx, irq;
  logic [31:0] rdata;

  int tests = 0, fails = 0;

  logic [15:0] div_m = 16'd433;
  logic        en_m = 0, irq_en_m = 0, ovf_m = 0;
  logic [7:0]  q[$];
  logic        tx_got[$], irq_got[$], tx_exp[$];
  logic [31:0] r_rd;
  logic        r_err, r_rv;

  always #5 clk = ~clk;

  uart_tx_device dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err), .tx_o(tx), .irq_o(irq)
  );

  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    r_rd = rdata; r_err = err; r_rv = rvalid;
    req = 0; we = 0; be = 0;
  endtask

  task automatic sample(input int n);
    tx_got.delete(); irq_got.delete();
    repeat (n) begin
      @(negedge clk);
      tx_got.push_back(tx);
      irq_got.push_back(irq);
    end
  endtask

  function automatic logic [31:0] status_m();
    int lvl = q.size();
    return 32'(lvl * 16 + (ovf_m ? 8 : 0) + (lvl == 0 ? 2 : 0) + (lvl == DEPTH ? 1 : 0));
  endfunction

  function automatic logic [31:0] ctrl_m();
    return {14'b0, irq_en_m, en_m, div_m};
  endfunction

  function automatic void model_push(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b);
    else ovf_m = 1;
  endfunction

  function automatic void build_exp(input logic [7:0] b, input int d);
    logic [9:0] frame = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      repeat (d + 1) tx_exp.push_back(frame[k]);
  endfunction

  function automatic void model_reset();
    q.delete(); div_m = 16'd433; en_m = 0; irq_en_m = 0; ovf_m = 0;
  endfunction

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    tests++;
    if ({tx, irq, rvalid, err, rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
      fails++; $display("FAIL reset_outputs: tx=%b irq=%b rvalid=%b err=%b rdata=%h, want tx=1 others 0", tx, irq, rvalid, err, rdata);
    end
    rst = 0;
    model_reset();
    @(negedge clk);
    bus(0, 32'h4, 0, 4'hF);
    tests++;
    if (r_rv !== 1 || r_rd !== status_m()) begin
      fails++; $display("FAIL reset_status: rvalid=%b rdata=%h want 1/%h", r_rv, r_rd, status_m());
    end
    bus(0, 32'h8, 0, 4'hF);
    tests++;
    if (r_rd !== ctrl_m()) begin
      fails++; $display("FAIL reset_ctrl: got %h want %h", r_rd, ctrl_m());
    end
  endtask

  task automatic test_frame();
    int bad = 0;
    div_m = 3; en_m = 1;
    bus(1, 32'h8, 32'h0001_0003, 4'hF);
    bus(1, 32'h0, 32'h41, 4'h1);
    tests++;
    if (tx !== 1'b1) begin
      fails++; $display("FAIL frame_latency: tx=%b one cycle after push, want 1", tx);
    end
    tx_exp.delete();
    build_exp(8'h41, 3);
    sample(tx_exp.size());
    foreach (tx_exp[i]) if (tx_got[i] !== tx_exp[i] || irq_got[i] !== 1'b0) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL frame_0x41: %0d of %0d clocks wrong (tx or irq)", bad, tx_exp.size());
    end
    repeat (3) @(negedge clk);
    bus(0, 32'h4, 0, 4'hF);
    tests++;
    if (r_rd !== status_m()) begin
      fails++; $display("FAIL frame_status: got %h want %h", r_rd, status_m());
    end
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 5; k++) begin
      int d = $urandom_range(0, 2);
      logic [7:0] b = 8'($urandom);
      int bad = 0;
      div_m = 16'(d); en_m = 1;
      bus(1, 32'h8, {14'b0, 2'b01, div_m}, 4'hF);
      bus(1, 32'h0, {24'($urandom), b}, 4'h1);
      tx_exp.delete();
      build_exp(b, d);
      sample(tx_exp.size());
      foreach (tx_exp[i]) if (tx_got[i] !== tx_exp[i]) bad++;
      tests++;
      if (bad != 0) begin
        fails++; $display("FAIL random_frame: byte %h div %0d, %0d clocks wrong", b, d, bad);
      end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    div_m = 1; en_m = 0;
    bus(1, 32'h8, 32'h0000_0001, 4'hF);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] b = 8'($urandom);
      bus(1, 32'h0, {24'd0, b}, 4'h1);
      model_push(b);
      tests++;
      if ({r_rv, r_err, r_rd} !== {1'b1, 1'b0, 32'd0}) begin
        fails++; $display("FAIL push_resp: rvalid=%b err=%b rdata=%h want 1/0/0", r_rv, r_err, r_rd);
      end
    end
    bus(0, 32'h4, 0, 4'hF);
    tests++;
    if (r_rd !== status_m()) begin
      fails++; $display("FAIL overflow_status: got %h want %h", r_rd, status_m());
    end
    en_m = 1;
    bus(1, 32'h8, 32'h0001_0001, 4'hF);
    tx_exp.delete();
    foreach (q[i]) build_exp(q[i], 1);
    q.delete();
    sample(tx_exp.size() + 4);
    foreach (tx_exp[i]) if (tx_got[i] !== tx_exp[i]) bad++;
    for (int i = tx_exp.size(); i < tx_got.size(); i++) if (tx_got[i] !== 1'b1) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL back_to_back: %0d clocks wrong over 4 frames", bad);
    end
    bus(0, 32'h4, 0, 4'hF);
    tests++;
    if (r_rd !== status_m()) begin
      fails++; $display("FAIL drained_status: got %h want %h", r_rd, status_m());
    end
    bus(1, 32'hC, 32'h1, 4'hF);
    ovf_m = 0;
    bus(0, 32'h4, 0, 4'hF);
    tests++;
    if (r_rd !== status_m()) begin
      fails++; $display("FAIL clr_status: got %h want %h", r_rd, status_m());
    end
  endtask

  task automatic test_irq();
    int bad = 0;
    div_m = 0; en_m = 1; irq_en_m = 1;
    bus(1, 32'h8, 32'h0003_0000, 4'hF);
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL irq_idle: got %b want 1", irq);
    end
    bus(1, 32'h0, 32'h55, 4'h1);
    tx_exp.delete();
    build_exp(8'h55, 0);
    sample(10);
    foreach (tx_exp[i]) if (tx_got[i] !== tx_exp[i] || irq_got[i] !== 1'b0) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL irq_frame: %0d clocks wrong (tx or irq)", bad);
    end
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL irq_early: got %b want 0 in first idle cycle", irq);
    end
    @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL irq_rise: got %b want 1", irq);
    end
    bus(1, 32'h0, 32'($urandom_range(0, 255)), 4'h1);
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL irq_push_fall: got %b want 0", irq);
    end
    repeat (12) @(negedge clk);
    tests++;
    if (irq !== 1'b1) begin
      fails++; $display("FAIL irq_rerise: got %b want 1", irq);
    end
    irq_en_m = 0;
    bus(1, 32'h8, 32'h0001_0000, 4'hF);
    @(negedge clk);
    tests++;
    if (irq !== 1'b0) begin
      fails++; $display("FAIL irq_en_clear: got %b want 0", irq);
    end
  endtask

  task automatic test_errors();
    div_m = 0; en_m = 0;
    bus(1, 32'h8, 32'h0, 4'hF);
    bus(1, 32'h0, 32'h0, 4'h1);
    model_push(8'h00);
    bus(0, 32'h10, 0, 4'hF);
    tests++;
    if ({r_rv, r_err, r_rd} !== {1'b1, 1'b1, 32'd0}) begin
      fails++; $display("FAIL err_read: rvalid=%b err=%b rdata=%h want 1/1/0", r_rv, r_err, r_rd);
    end
    bus(1, 32'h3FC, 32'hFFFF_FFFF, 4'hF);
    tests++;
    if ({r_rv, r_err, r_rd} !== {1'b1, 1'b1, 32'd0}) begin
      fails++; $display("FAIL err_write: rvalid=%b err=%b rdata=%h want 1/1/0", r_rv, r_err, r_rd);
    end
    bus(1, 32'h0, 32'h77, 4'b1110);
    bus(0, 32'h0, 0, 4'hF);
    tests++;
    if ({r_err, r_rd} !== {1'b0, 32'd0}) begin
      fails++; $display("FAIL txdata_read: err=%b rdata=%h want 0/0", r_err, r_rd);
    end
    bus(0, 32'h4, 0, 4'hF);
    tests++;
    if (r_rd !== status_m()) begin
      fails++; $display("FAIL err_no_effect_status: got %h want %h", r_rd, status_m());
    end
    bus(1, 32'h8, 32'hFFFF_AB05, 4'b0001);
    div_m[7:0] = 8'h05;
    bus(0, 32'h8, 0, 4'hF);
    tests++;
    if (r_rd !== ctrl_m()) begin
      fails++; $display("FAIL ctrl_byte_en: got %h want %h", r_rd, ctrl_m());
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    bus(1, 32'h8, 32'h0001_0003, 4'hF);
    repeat (8) @(negedge clk);
    tests++;
    if (tx !== 1'b0) begin
      fails++; $display("FAIL mid_data: tx=%b want 0 inside zero-byte frame", tx);
    end
    rst = 1;
    #1;
    tests++;
    if ({tx, irq, rvalid} !== 3'b100) begin
      fails++; $display("FAIL async_reset: tx=%b irq=%b rvalid=%b want 1/0/0", tx, irq, rvalid);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    sample(20);
    foreach (tx_got[i]) if (tx_got[i] !== 1'b1) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL post_reset_idle: tx low on %0d clocks", bad);
    end
    bus(0, 32'h4, 0, 4'hF);
    tests++;
    if (r_rd !== status_m()) begin
      fails++; $display("FAIL post_reset_status: got %h want %h", r_rd, status_m());
    end
    bus(0, 32'h8, 0, 4'hF);
    tests++;
    if (r_rd !== ctrl_m()) begin
      fails++; $display("FAIL post_reset_ctrl: got %h want %h", r_rd, ctrl_m());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frame();
    test_random_frames();
    test_back_to_back();
    test_irq();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
